// File: rtl/mc_timer_pkg.sv
// Shared types and helpers for the multi-channel millisecond timer.
// Pure declarations: no logic, no latency, no backpressure.
package mc_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // All-ones value of a WIDTH-bit counter. This is the point where the count saturates.
    function automatic logic [31:0] sat_value(input int unsigned width);
        logic [63:0] one_hot;
        one_hot = 64'd1 << width;
        return 32'(one_hot - 64'd1);
    endfunction

endpackage

// File: rtl/ms_timer_channel.sv
// One stopwatch channel with pause, a result latch, timeout and saturation. All outputs are registered.
// No backpressure: start, stop and pause are sampled on every clk_1khz edge.
module ms_timer_channel
    import mc_timer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic             clk_1khz,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [WIDTH-1:0] time_ms,
    output logic [WIDTH-1:0] result_ms,
    output logic             active,
    output logic             done,
    output logic             timeout,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] SAT   = WIDTH'(sat_value(WIDTH));
    localparam logic [WIDTH-1:0] TO    = WIDTH'(TIMEOUT_MS);
    localparam bit               TO_EN = (TIMEOUT_MS != 0);

    state_t           state, state_n;
    logic [WIDTH-1:0] count, count_n, result_n;
    logic [WIDTH-1:0] count_inc;
    logic             done_n, timeout_n, overflow_n;

    assign count_inc = count + 1'b1;

    always_ff @(posedge clk_1khz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            result_ms <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            result_ms <= result_n;
            done      <= done_n;
            timeout   <= timeout_n;
            overflow  <= overflow_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        result_n   = result_ms;
        done_n     = 1'b0;
        timeout_n  = timeout;
        overflow_n = overflow;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n    = RUN;
                    count_n    = '0;
                    timeout_n  = 1'b0;
                    overflow_n = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    result_n = count;
                    done_n   = 1'b1;
                    state_n  = DONE;
                end else if (pause) begin
                    state_n = PAUSED;
                end else if (TO_EN && count_inc == TO) begin
                    count_n   = TO;
                    result_n  = TO;
                    done_n    = 1'b1;
                    timeout_n = 1'b1;
                    state_n   = DONE;
                end else if (!TO_EN && count == SAT) begin
                    overflow_n = 1'b1;
                end else begin
                    count_n = count_inc;
                end
            end
            PAUSED: begin
                // The resume edge only changes state; counting restarts on the next edge.
                if (stop) begin
                    result_n = count;
                    done_n   = 1'b1;
                    state_n  = DONE;
                end else if (!pause) begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign time_ms = count;
    assign active  = (state == RUN) || (state == PAUSED);

endmodule

// File: rtl/multi_channel_ms_timer.sv
// Runs CHANNELS independent ms_timer_channel instances and packs their outputs into flat buses.
// Latency and backpressure are those of one channel: registered outputs, inputs sampled every edge.
module multi_channel_ms_timer
    import mc_timer_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 16,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic                      clk_1khz,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       pause,
    output logic [CHANNELS*WIDTH-1:0] time_ms,
    output logic [CHANNELS*WIDTH-1:0] result_ms,
    output logic [CHANNELS-1:0]       active,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       timeout,
    output logic [CHANNELS-1:0]       overflow
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ms_timer_channel #(
            .WIDTH      (WIDTH),
            .TIMEOUT_MS (TIMEOUT_MS)
        ) u_ch (
            .clk_1khz  (clk_1khz),
            .reset     (reset),
            .start     (start[i]),
            .stop      (stop[i]),
            .pause     (pause[i]),
            .time_ms   (time_ms[i*WIDTH +: WIDTH]),
            .result_ms (result_ms[i*WIDTH +: WIDTH]),
            .active    (active[i]),
            .done      (done[i]),
            .timeout   (timeout[i]),
            .overflow  (overflow[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_ms_timer.sv
// Scoreboard bench: stimulus pushes the expected result and timeout flag, and the monitor pops them on done.
// A second instance uses WIDTH=4 and TIMEOUT_MS=0 to exercise saturation.
module tb_multi_channel_ms_timer;

    typedef struct packed {
        logic [15:0] res;
        logic        to;
    } exp_t;

    logic        clk_1khz = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  start = '0, stop = '0, pause = '0;
    logic [63:0] time_ms, result_ms;
    logic [3:0]  active, done, timeout, overflow;

    logic        s_start = 1'b0, s_stop = 1'b0, s_pause = 1'b0;
    logic [3:0]  s_time, s_result;
    logic        s_active, s_done, s_timeout, s_overflow;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q [5][$];

    multi_channel_ms_timer dut (
        .clk_1khz (clk_1khz), .reset (reset),
        .start (start), .stop (stop), .pause (pause),
        .time_ms (time_ms), .result_ms (result_ms),
        .active (active), .done (done), .timeout (timeout), .overflow (overflow)
    );

    multi_channel_ms_timer #(.CHANNELS(1), .WIDTH(4), .TIMEOUT_MS(0)) dut_sat (
        .clk_1khz (clk_1khz), .reset (reset),
        .start (s_start), .stop (s_stop), .pause (s_pause),
        .time_ms (s_time), .result_ms (s_result),
        .active (s_active), .done (s_done), .timeout (s_timeout), .overflow (s_overflow)
    );

    always #5 clk_1khz = ~clk_1khz;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int ch, input int r, input bit t);
        exp_t e;
        e.res = 16'(r);
        e.to  = t;
        exp_q[ch].push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_1khz);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] st, input logic [3:0] sp);
        start = st;
        stop  = sp;
        step(1);
        start = '0;
        stop  = '0;
    endtask

    function automatic logic [15:0] tm(input int ch);
        return time_ms[ch*16 +: 16];
    endfunction

    task automatic mon_one(input int ch, input logic d, input logic [15:0] r, input logic t);
        exp_t e;
        if (d) begin
            if (exp_q[ch].size() == 0) begin
                chk($sformatf("unexpected_done_ch%0d", ch), 64'd1, 64'd0);
            end else begin
                e = exp_q[ch].pop_front();
                chk($sformatf("result_ch%0d", ch), 64'(r), 64'(e.res));
                chk($sformatf("timeout_flag_ch%0d", ch), 64'(t), 64'(e.to));
            end
        end
    endtask

    always @(negedge clk_1khz) begin
        if (!reset) begin
            for (int ch = 0; ch < 4; ch++)
                mon_one(ch, done[ch], result_ms[ch*16 +: 16], timeout[ch]);
            mon_one(4, s_done, {12'd0, s_result}, s_timeout);
        end
    end

    int start_t [4] = '{0, 3, 5, 8};
    int stop_t  [4] = '{25, 31, 20, 30};

    initial begin
        logic [3:0] st, sp;

        // Reset state
        repeat (2) @(posedge clk_1khz);
        #1;
        chk("rst_time", time_ms, 64'd0);
        chk("rst_result", result_ms, 64'd0);
        chk("rst_flags", {active, done, timeout, overflow}, 64'd0);
        chk("rst_sat", {s_time, s_result, s_active, s_done, s_timeout, s_overflow}, 64'd0);
        reset = 1'b0;
        step(3);

        // Basic timing on ch0: stop 50 edges after the start gives 49
        drive(4'b0001, 4'b0000);
        chk("ch0_time_after_start", 64'(tm(0)), 64'd0);
        chk("ch0_active", 64'(active[0]), 64'd1);
        step(49);
        chk("ch0_time_49", 64'(tm(0)), 64'd49);
        push(0, 49, 1'b0);
        drive(4'b0000, 4'b0001);
        chk("ch0_done_hi", 64'(done[0]), 64'd1);
        chk("ch0_inactive", 64'(active[0]), 64'd0);
        step(1);
        chk("ch0_done_lo", 64'(done[0]), 64'd0);
        chk("ch0_time_holds", 64'(tm(0)), 64'd49);

        // Pause on ch1 during edges 20..29 of a 100-edge run. The resume edge also doesn't count: 99-11=88
        drive(4'b0010, 4'b0000);
        step(19);
        pause[1] = 1'b1;
        step(10);
        chk("ch1_time_paused", 64'(tm(1)), 64'd19);
        chk("ch1_active_paused", 64'(active[1]), 64'd1);
        pause[1] = 1'b0;
        step(70);
        push(1, 88, 1'b0);
        drive(4'b0000, 4'b0010);
        step(1);

        // Stop while paused captures the held count
        drive(4'b0010, 4'b0000);
        step(5);
        pause[1] = 1'b1;
        step(3);
        push(1, 5, 1'b0);
        drive(4'b0000, 4'b0010);
        pause[1] = 1'b0;
        chk("ch1_pstop_inactive", 64'(active[1]), 64'd0);
        step(1);

        // Timeout on ch2 after 2000 edges
        drive(4'b0100, 4'b0000);
        push(2, 2000, 1'b1);
        step(1999);
        chk("ch2_time_1999", 64'(tm(2)), 64'd1999);
        chk("ch2_no_timeout_yet", 64'(timeout[2]), 64'd0);
        step(1);
        chk("ch2_time_2000", 64'(tm(2)), 64'd2000);
        chk("ch2_timeout_set", 64'(timeout[2]), 64'd1);
        chk("ch2_inactive", 64'(active[2]), 64'd0);
        chk("ch2_done", 64'(done[2]), 64'd1);
        step(2);
        chk("ch2_timeout_sticky", 64'(timeout[2]), 64'd1);
        drive(4'b0100, 4'b0000);
        chk("ch2_timeout_cleared", 64'(timeout[2]), 64'd0);
        chk("ch2_restart_time", 64'(tm(2)), 64'd0);
        push(2, 0, 1'b0);
        drive(4'b0000, 4'b0100);
        step(1);

        // Simultaneous events on ch3
        drive(4'b1000, 4'b1000);
        chk("ch3_startstop_idle_active", 64'(active[3]), 64'd1);
        chk("ch3_startstop_idle_time", 64'(tm(3)), 64'd0);
        step(4);
        drive(4'b1000, 4'b0000);
        chk("ch3_retrigger_ignored", 64'(tm(3)), 64'd5);
        chk("ch3_still_active", 64'(active[3]), 64'd1);
        push(3, 5, 1'b0);
        drive(4'b1000, 4'b1000);
        chk("ch3_stop_wins", 64'(active[3]), 64'd0);
        step(1);

        // Saturation on the WIDTH=4, TIMEOUT_MS=0 instance
        s_start = 1'b1;
        step(1);
        s_start = 1'b0;
        step(20);
        chk("sat_time", 64'(s_time), 64'd15);
        chk("sat_overflow", 64'(s_overflow), 64'd1);
        chk("sat_active", 64'(s_active), 64'd1);
        push(4, 15, 1'b0);
        s_stop = 1'b1;
        step(1);
        s_stop = 1'b0;
        chk("sat_stopped", 64'(s_active), 64'd0);
        chk("sat_overflow_sticky", 64'(s_overflow), 64'd1);
        step(1);

        // Independent channels with staggered starts and stops
        for (int t = 0; t <= 31; t++) begin
            st = '0;
            sp = '0;
            for (int ch = 0; ch < 4; ch++) begin
                if (t == start_t[ch]) st[ch] = 1'b1;
                if (t == stop_t[ch]) begin
                    sp[ch] = 1'b1;
                    push(ch, stop_t[ch] - start_t[ch] - 1, 1'b0);
                end
            end
            drive(st, sp);
        end
        step(2);
        chk("indep_results", result_ms, {16'd21, 16'd14, 16'd27, 16'd24});

        // Asynchronous reset in the middle of a run
        drive(4'b1111, 4'b0000);
        step(7);
        chk("pre_reset_time", time_ms, {16'd7, 16'd7, 16'd7, 16'd7});
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_time", time_ms, 64'd0);
        chk("mid_rst_result", result_ms, 64'd0);
        chk("mid_rst_flags", {active, done, timeout, overflow}, 64'd0);
        chk("mid_rst_sat", {s_time, s_result, s_active, s_done, s_timeout, s_overflow}, 64'd0);
        step(1);
        reset = 1'b0;
        step(3);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_active", 64'(active), 64'd0);

        for (int ch = 0; ch < 5; ch++)
            chk($sformatf("pending_ch%0d", ch), 64'(exp_q[ch].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
